// File: rtl/wless_burst_framer.sv
// Buffers controller bytes and emits HEADER/length/payload/check frames as write strobes to the node UART.
// Define FRAMER_CRC8_EN for a CRC-8 (poly 0x07) check byte; otherwise the check is the XOR of the payload.
module wless_burst_framer #(
    parameter int DATA_WIDTH                 = 8,
    parameter int FIFO_ADDR_W                = 6,
    parameter int START_WIRELESS_TRANS_VALUE = 58,
    parameter int MAX_PAYLOAD                = 58,
    parameter int IDLE_TIMEOUT               = 5000,
    parameter logic [DATA_WIDTH-1:0] HEADER_BYTE = 8'hA5
) (
    input  logic                  internal_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_use,
    input  logic                  out_full,
    output logic                  burst_active,
    output logic                  aux
);
    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int CW    = FIFO_ADDR_W + 1;
    localparam int TW    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] START_C = CW'(START_WIRELESS_TRANS_VALUE);
    localparam logic [CW-1:0] MAXP_C  = CW'(MAX_PAYLOAD);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [TW-1:0] TMAX_C  = TW'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, HDR, LEN, PAY, CHK} state_t;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]          count, len, rem;
    logic [TW-1:0]          timer;
    logic [DATA_WIDTH-1:0]  chk;
    state_t                 state, state_n;

    logic                  wr_en, rd_en, trig, strobe;
    logic [DATA_WIDTH-1:0] byte_n;
    logic [DATA_WIDTH-1:0] head;

    function automatic logic [DATA_WIDTH-1:0] fold(input logic [DATA_WIDTH-1:0] c,
                                                   input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] x;
        x = c ^ d;
`ifdef FRAMER_CRC8_EN
        for (int i = 0; i < 8; i++)
            x = x[DATA_WIDTH-1] ? ((x << 1) ^ DATA_WIDTH'(8'h07)) : (x << 1);
`endif
        return x;
    endfunction

    assign in_ready     = (count != DEPTH_C);
    assign wr_en        = in_valid && in_ready;
    assign head         = mem[rd_ptr];
    assign burst_active = (state != IDLE);
    assign aux          = (state == IDLE) && (count == '0);

    always_comb begin
        state_n = state;
        trig    = 1'b0;
        strobe  = 1'b0;
        rd_en   = 1'b0;
        byte_n  = out_data;
        case (state)
            IDLE: begin
                if (count >= START_C || (count != '0 && timer == TMAX_C)) begin
                    trig    = 1'b1;
                    state_n = HDR;
                end
            end
            HDR: if (!out_full) begin
                strobe  = 1'b1;
                byte_n  = HEADER_BYTE;
                state_n = LEN;
            end
            LEN: if (!out_full) begin
                strobe  = 1'b1;
                byte_n  = DATA_WIDTH'(len);
                state_n = PAY;
            end
            PAY: if (!out_full) begin
                strobe = 1'b1;
                rd_en  = 1'b1;
                byte_n = head;
                if (rem == ONE_C) state_n = CHK;
            end
            CHK: if (!out_full) begin
                strobe  = 1'b1;
                byte_n  = chk;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Storage has no reset: the pointers and count define what is valid.
    always_ff @(posedge internal_clk) begin
        if (wr_en) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge internal_clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            timer    <= '0;
            state    <= IDLE;
            len      <= '0;
            rem      <= '0;
            chk      <= '0;
            out_use  <= 1'b0;
            out_data <= '0;
        end else begin
            state    <= state_n;
            out_use  <= strobe;
            out_data <= byte_n;
            if (wr_en) wr_ptr <= wr_ptr + FIFO_ADDR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
            if (wr_en || count == '0) timer <= '0;
            else if (timer != TMAX_C) timer <= timer + TW'(1);
            if (trig) begin
                len <= (count > MAXP_C) ? MAXP_C : count;
                rem <= (count > MAXP_C) ? MAXP_C : count;
                chk <= '0;
            end
            if (rd_en) begin
                chk <= fold(chk, head);
                rem <= rem - ONE_C;
            end
        end
    end
endmodule

// File: tb/tb_wless_burst_framer.sv
// Scoreboard bench: stimulus frames expected bytes into a queue, a negedge monitor pops and compares.
module tb_wless_burst_framer;
    localparam int TMO = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_use;
    logic       out_full = 1'b0;
    logic       burst_active;
    logic       aux;

    wless_burst_framer dut (
        .internal_clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_use(out_use), .out_full(out_full),
        .burst_active(burst_active), .aux(aux)
    );

    always #5 clk = ~clk;

    int         checks = 0, fails = 0, strobes = 0, cyc = 0;
    logic [7:0] exp_q [$];
    logic [7:0] bytes_q [$];
    logic [7:0] last_byte = '0;
    bit         rand_full = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_use) begin
            strobes++;
            last_byte = out_data;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_strobe: got %0h expected no strobe", out_data);
            end else begin
                check("strobe_byte", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rand_full) out_full = ($urandom_range(3) == 0);
    endtask

    // Reference framing: header, length, payload, then XOR or bit-serial CRC-8 of the payload.
    task automatic push_frame(input int n);
        logic [7:0] c, b;
        c = '0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
            b = bytes_q.pop_front();
            exp_q.push_back(b);
`ifdef FRAMER_CRC8_EN
            for (int i = 7; i >= 0; i--) begin
                if (c[7] ^ b[i]) c = {c[6:0], 1'b0} ^ 8'h07;
                else             c = {c[6:0], 1'b0};
            end
`else
            c = c ^ b;
`endif
        end
        exp_q.push_back(c);
    endtask

    task automatic flush_model();
        while (bytes_q.size() > 0)
            push_frame(bytes_q.size() > 58 ? 58 : bytes_q.size());
    endtask

    task automatic wr(input logic [7:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 20000) begin tick(); n++; end
        if (!in_ready) begin
            check("write_accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        bytes_q.push_back(d);
        if (bytes_q.size() == 58) push_frame(58);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin tick(); n++; end
        check("drain_remaining", exp_q.size(), 0);
        repeat (4) tick();
    endtask

    task automatic wait_strobes(input int target, input int limit);
        int n = 0;
        while (strobes < target && n < limit) begin tick(); n++; end
        check("wait_strobes_reached", int'(strobes >= target), 1);
    endtask

    initial begin
        int snap, s2, w, d, n;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_in_ready", in_ready, 1);
        check("reset_aux", aux, 1);
        check("reset_out_use", out_use, 0);
        check("reset_burst_active", burst_active, 0);
        check("reset_out_data", out_data, 0);

        // Threshold burst of 58 sequential bytes.
        snap = strobes;
        for (int i = 0; i < 58; i++) wr(8'(i));
        drain(300);
        check("t1_strobe_count", strobes - snap, 61);
        check("t1_aux_after", aux, 1);
        check("t1_burst_active_after", burst_active, 0);

        // Timeout burst of three bytes.
        snap = strobes;
        wr(8'h11); wr(8'h22); wr(8'h44);
        w = cyc;
        flush_model();
        n = 0;
        while (strobes == snap && n < TMO + 100) begin tick(); n++; end
        d = cyc - w;
        check("t2_no_early_burst", int'(d >= TMO), 1);
        check("t2_burst_not_late", int'(d <= TMO + 3), 1);
        drain(100);
        check("t2_strobe_count", strobes - snap, 6);
`ifndef FRAMER_CRC8_EN
        check("t2_xor_check", last_byte, 8'h77);
`else
        snap = strobes;
        for (int i = 0; i < 9; i++) wr(8'h31 + 8'(i));
        flush_model();
        drain(TMO + 200);
        check("t3_crc_check", last_byte, 8'hF4);
        check("t3_strobe_count", strobes - snap, 12);
`endif

        // Back-pressure held mid-payload.
        snap = strobes;
        for (int i = 0; i < 58; i++) wr(8'($urandom));
        wait_strobes(snap + 12, 500);
        out_full = 1'b1;
        tick();
        s2 = strobes;
        repeat (100) tick();
        check("t4_no_strobe_while_full", strobes - s2, 0);
        check("t4_out_use_low", out_use, 0);
        out_full = 1'b0;
        drain(300);
        check("t4_strobe_count", strobes - snap, 61);

        // Fill buffer completely while the UART is full.
        snap = strobes;
        out_full = 1'b1;
        for (int i = 0; i < 64; i++) wr(8'h80 + 8'(i));
        check("t5_in_ready_full", in_ready, 0);
        in_data  = 8'hEE;
        in_valid = 1'b1;
        repeat (5) tick();
        check("t5_in_ready_still_full", in_ready, 0);
        in_valid = 1'b0;
        flush_model();
        out_full = 1'b0;
        drain(TMO + 500);
        check("t5_strobe_count", strobes - snap, 70);

        // Reset during payload abandons the frame.
        snap = strobes;
        for (int i = 0; i < 58; i++) wr(8'($urandom));
        wait_strobes(snap + 10, 500);
        rst = 1'b1;
        exp_q.delete();
        bytes_q.delete();
        tick();
        rst = 1'b0;
        check("t6_out_use", out_use, 0);
        check("t6_burst_active", burst_active, 0);
        check("t6_aux", aux, 1);
        check("t6_in_ready", in_ready, 1);
        s2 = strobes;
        repeat (300) tick();
        check("t6_no_more_strobes", strobes - s2, 0);

        // Randomized lengths, gaps and back-pressure.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(150, 1);
            snap = strobes;
            rand_full = 1'b1;
            for (int i = 0; i < n; i++) begin
                wr(8'($urandom));
                repeat ($urandom_range(3)) tick();
            end
            flush_model();
            drain(TMO + 2000);
            rand_full = 1'b0;
            out_full  = 1'b0;
            check("rand_strobe_count", strobes - snap, n + 3 * ((n + 57) / 58));
            check("rand_aux_after", aux, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
